mega_regs_ctx: RTL and testbench

Context save/restore engine for the mega core register file. It acts as the access master on the register-file ports: read address/mode out, read data in, and write address/data/strobe/mode out. In save mode it reads a contiguous register range and streams it out byte-by-byte; in restore mode it takes bytes from an input stream and writes them back. It is used for debugger and interrupt-context tooling, and it owns the register-file ports only while the core grants them.

---
 rtl/mega_regs_ctx.sv | 240 ++++++++++++++++++++++++
 tb/tb_mega_regs_ctx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mega_regs_ctx.sv
// rtl/mega_regs_ctx.sv - register-file context save/restore engine (byte streams out/in)
// Optional trailing XOR checksum byte: define MEGA_REGS_CTX_CSUM_EN.
module mega_regs_ctx #(
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dir,
  input  logic [4:0]  first,
  input  logic [4:0]  last,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        own_req,
  input  logic        own_gnt,
  output logic [4:0]  rs1a,
  output logic        rs1m,
  input  logic [15:0] rs1,
  output logic [4:0]  rda,
  output logic [15:0] rd,
  output logic        rdw,
  output logic        rdm,
  output logic [7:0]  so_data,
  output logic        so_valid,
  input  logic        so_ready,
  input  logic [7:0]  si_data,
  input  logic        si_valid,
  output logic        si_ready
);

`ifdef MEGA_REGS_CTX_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [5:0] REG_LIMIT = 6'(REG_COUNT);

  typedef enum logic [3:0] {
    IDLE, CHK, ACQ, SAVE_RD, SAVE_TX, RST_RX, RST_WR, CSUM, FIN
  } state_t;

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [4:0]  first_q, first_d;
  logic [4:0]  last_q, last_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        own_req_q, own_req_d;
  logic [7:0]  so_data_q, so_data_d;
  logic        so_valid_q, so_valid_d;
  logic [4:0]  rda_q, rda_d;
  logic [7:0]  rd_q, rd_d;
  logic        rdw_q, rdw_d;
  logic [7:0]  csum_q, csum_d;

  logic so_fire, si_fire, at_last, range_bad;
  logic unused_rs1_hi;

  assign unused_rs1_hi = ^rs1[15:8];

  // Stream valid and write strobe are gated by the grant so a lost grant
  // drops them in the same cycle rather than one edge later.
  assign busy     = busy_q;
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign own_req  = own_req_q;
  assign rs1a     = (state_q == SAVE_RD) ? ptr_q : 5'd0;
  assign rs1m     = 1'b0;
  assign rda      = rda_q;
  assign rd       = {8'h00, rd_q};
  assign rdw      = rdw_q & own_gnt;
  assign rdm      = 1'b0;
  assign so_data  = so_data_q;
  assign so_valid = so_valid_q & own_gnt;
  assign si_ready = own_gnt & ((state_q == RST_RX) | ((state_q == CSUM) & dir_q));

  assign so_fire   = so_valid & so_ready;
  assign si_fire   = si_valid & si_ready;
  assign at_last   = (ptr_q == last_q);
  assign range_bad = (first_q > last_q) || ({1'b0, last_q} >= REG_LIMIT);

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    first_d    = first_q;
    last_d     = last_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    err_d      = err_q;
    own_req_d  = own_req_q;
    so_data_d  = so_data_q;
    so_valid_d = so_valid_q;
    rda_d      = rda_q;
    rd_d       = rd_q;
    rdw_d      = rdw_q;
    csum_d     = csum_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dir_d   = dir;
          first_d = first;
          last_d  = last;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          csum_d  = 8'h00;
          state_d = CHK;
        end
      end
      CHK: begin
        if (range_bad) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          own_req_d = 1'b1;
          ptr_d     = first_q;
          state_d   = ACQ;
        end
      end
      ACQ: begin
        if (own_gnt) state_d = dir_q ? RST_RX : SAVE_RD;
      end
      SAVE_RD: begin
        if (!own_gnt) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          so_data_d  = rs1[7:0];
          so_valid_d = 1'b1;
          csum_d     = csum_q ^ rs1[7:0];
          state_d    = SAVE_TX;
        end
      end
      SAVE_TX: begin
        if (!own_gnt) begin
          so_valid_d = 1'b0;
          err_d      = 1'b1;
          state_d    = FIN;
        end else if (so_fire) begin
          if (!at_last) begin
            so_valid_d = 1'b0;
            ptr_d      = ptr_q + 5'd1;
            state_d    = SAVE_RD;
          end else if (CSUM_EN) begin
            // Checksum byte follows back-to-back with the last register byte.
            so_data_d  = csum_q;
            so_valid_d = 1'b1;
            state_d    = CSUM;
          end else begin
            so_valid_d = 1'b0;
            state_d    = FIN;
          end
        end
      end
      RST_RX: begin
        if (!own_gnt) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (si_fire) begin
          rda_d   = ptr_q;
          rd_d    = si_data;
          rdw_d   = 1'b1;
          csum_d  = csum_q ^ si_data;
          state_d = RST_WR;
        end
      end
      RST_WR: begin
        rdw_d = 1'b0;
        if (!own_gnt) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else if (!at_last) begin
          ptr_d   = ptr_q + 5'd1;
          state_d = RST_RX;
        end else begin
          state_d = CSUM_EN ? CSUM : FIN;
        end
      end
      CSUM: begin
        if (!own_gnt) begin
          so_valid_d = 1'b0;
          err_d      = 1'b1;
          state_d    = FIN;
        end else if (dir_q) begin
          if (si_fire) begin
            if (si_data != csum_q) err_d = 1'b1;
            state_d = FIN;
          end
        end else if (so_fire) begin
          so_valid_d = 1'b0;
          state_d    = FIN;
        end
      end
      FIN: begin
        own_req_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      first_q    <= 5'd0;
      last_q     <= 5'd0;
      ptr_q      <= 5'd0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      own_req_q  <= 1'b0;
      so_data_q  <= 8'h00;
      so_valid_q <= 1'b0;
      rda_q      <= 5'd0;
      rd_q       <= 8'h00;
      rdw_q      <= 1'b0;
      csum_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      first_q    <= first_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      own_req_q  <= own_req_d;
      so_data_q  <= so_data_d;
      so_valid_q <= so_valid_d;
      rda_q      <= rda_d;
      rd_q       <= rd_d;
      rdw_q      <= rdw_d;
      csum_q     <= csum_d;
    end
  end

endmodule

// File: tb/tb_mega_regs_ctx.sv
// tb/tb_mega_regs_ctx.sv - scoreboard bench for mega_regs_ctx
module tb_mega_regs_ctx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, dir;
  logic [4:0]  first, last;
  logic        busy, done, err, own_req, own_gnt;
  logic [4:0]  rs1a, rda;
  logic        rs1m, rdw, rdm;
  logic [15:0] rs1, rd;
  logic [7:0]  so_data, si_data;
  logic        so_valid, so_ready, si_valid, si_ready;

  logic        b_start;
  logic        b_busy, b_done, b_err, b_own_req, b_rs1m, b_rdw, b_rdm, b_so_valid, b_si_ready;
  logic [4:0]  b_rs1a, b_rda;
  logic [15:0] b_rd;
  logic [7:0]  b_so_data;

  logic        gnt_auto, gnt_force;
  logic [7:0]  regs [32];
  logic [7:0]  si_q [$];
  logic [7:0]  exp_so [$];
  logic [12:0] exp_wr [$];
  logic        exp_done [$];
  logic        si_hs = 1'b0;
  logic        own_req_seen;
  int          so_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign own_gnt = gnt_auto ? own_req : gnt_force;
  assign rs1     = {8'hEE, regs[rs1a]};

  mega_regs_ctx #(.REG_COUNT(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .first(first), .last(last),
    .busy(busy), .done(done), .err(err), .own_req(own_req), .own_gnt(own_gnt),
    .rs1a(rs1a), .rs1m(rs1m), .rs1(rs1), .rda(rda), .rd(rd), .rdw(rdw), .rdm(rdm),
    .so_data(so_data), .so_valid(so_valid), .so_ready(so_ready),
    .si_data(si_data), .si_valid(si_valid), .si_ready(si_ready)
  );

  mega_regs_ctx #(.REG_COUNT(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(b_start), .dir(1'b0), .first(5'd0), .last(5'd31),
    .busy(b_busy), .done(b_done), .err(b_err), .own_req(b_own_req), .own_gnt(1'b0),
    .rs1a(b_rs1a), .rs1m(b_rs1m), .rs1(16'h0000), .rda(b_rda), .rd(b_rd), .rdw(b_rdw), .rdm(b_rdm),
    .so_data(b_so_data), .so_valid(b_so_valid), .so_ready(1'b0),
    .si_data(8'h00), .si_valid(1'b0), .si_ready(b_si_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, required no event", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic d, input logic [4:0] f, input logic [4:0] l);
    start = 1'b1; dir = d; first = f; last = l;
    tick();
    start = 1'b0; dir = ~d; first = 5'd31; last = 5'd0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check({name, "_done_timeout"}, done, 1);
    tick();
    check({name, "_own_req_after"}, own_req, 0);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // Stream source: pops accepted bytes and presents the next one.
  always @(posedge clk) begin
    if (si_hs) void'(si_q.pop_front());
    #2;
    si_valid = (si_q.size() != 0);
    si_data  = (si_q.size() != 0) ? si_q[0] : 8'h00;
  end

  always @(posedge clk) begin
    if (rdw) regs[rda] <= rd[7:0];
  end

  // Monitor: compares every observed transfer against the scoreboard queues.
  always @(negedge clk) begin
    si_hs = si_valid && si_ready;
    if (!rst) begin
      if (own_req) own_req_seen = 1'b1;
      if (rdw && !own_gnt) unexpected("rdw_without_gnt", 32'(rda));
      if (so_valid && so_ready) begin
        so_cnt++;
        if (exp_so.size() == 0) unexpected("so_extra_byte", 32'(so_data));
        else check("so_data", 32'(so_data), 32'(exp_so.pop_front()));
      end
      if (rdw) begin
        check("rdm", 32'(rdm), 0);
        if (exp_wr.size() == 0) unexpected("rdw_extra_write", 32'({rda, rd[7:0]}));
        else check("write_addr_data", 32'({rda, rd}), 32'({exp_wr[0][12:8], 8'h00, exp_wr[0][7:0]}));
        if (exp_wr.size() != 0) void'(exp_wr.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done_extra", 32'(err));
        else check("err_at_done", 32'(err), 32'(exp_done.pop_front()));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; dir = 1'b0; first = 5'd0; last = 5'd0;
    b_start = 1'b0; gnt_auto = 1'b1; gnt_force = 1'b0; so_ready = 1'b1;
    si_valid = 1'b0; si_data = 8'h00;
    for (int i = 0; i < 32; i++) regs[i] = 8'h00;
    regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, done, err, own_req, rdw, so_valid, si_ready, rs1m, rdm}, 0);
    check("rst_addr", {rs1a, rda, rd, so_data}, 0);
    rst = 1'b0;
    tick();

    // Save r0..r3 with free-running ready.
    exp_so.push_back(8'h11); exp_so.push_back(8'h22); exp_so.push_back(8'h33); exp_so.push_back(8'h44);
`ifdef MEGA_REGS_CTX_CSUM_EN
    exp_so.push_back(8'h44);
`endif
    exp_done.push_back(1'b0);
    do_start(1'b0, 5'd0, 5'd3);
    wait_done("save");

    // Same save with back-pressure while byte 0x22 is offered.
    exp_so.push_back(8'h11); exp_so.push_back(8'h22); exp_so.push_back(8'h33); exp_so.push_back(8'h44);
`ifdef MEGA_REGS_CTX_CSUM_EN
    exp_so.push_back(8'h44);
`endif
    exp_done.push_back(1'b0);
    do_start(1'b0, 5'd0, 5'd3);
    n = 0;
    while (!(so_valid && so_data == 8'h22) && n < 100) begin tick(); n++; end
    so_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_hold", {so_valid, so_data}, {1'b1, 8'h22});
      tick();
    end
    so_ready = 1'b1;
    wait_done("save_stall");

    // Restore r16..r17.
    si_q.push_back(8'hA5); si_q.push_back(8'h5A);
    exp_wr.push_back({5'd16, 8'hA5}); exp_wr.push_back({5'd17, 8'h5A});
`ifdef MEGA_REGS_CTX_CSUM_EN
    si_q.push_back(8'hFF);
`endif
    exp_done.push_back(1'b0);
    do_start(1'b1, 5'd16, 5'd17);
    wait_done("restore");
    check("regfile_r17", 32'(regs[17]), 32'h5A);

`ifdef MEGA_REGS_CTX_CSUM_EN
    si_q.push_back(8'hA5); si_q.push_back(8'h5A); si_q.push_back(8'h00);
    exp_wr.push_back({5'd16, 8'hA5}); exp_wr.push_back({5'd17, 8'h5A});
    exp_done.push_back(1'b1);
    do_start(1'b1, 5'd16, 5'd17);
    wait_done("restore_bad_csum");
`else
    si_q.push_back(8'h3C);
    exp_wr.push_back({5'd16, 8'h3C});
    exp_done.push_back(1'b0);
    do_start(1'b1, 5'd16, 5'd16);
    wait_done("restore_single");
    check("regfile_r16", 32'(regs[16]), 32'h3C);
`endif

    // Range error: first > last.
    own_req_seen = 1'b0;
    exp_done.push_back(1'b1);
    do_start(1'b0, 5'd5, 5'd3);
    check("range_busy", busy, 1);
    tick();
    check("range_done_2nd_cycle", {done, err}, 2'b11);
    tick();
    check("range_own_req_never", own_req_seen, 0);

    // Range error: last beyond a 16-register file.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    check("range16_done_2nd_cycle", {b_done, b_err}, 2'b11);
    tick();
    check("range16_after", {b_done, b_err, b_own_req, b_busy}, 4'b0100);

    // Grant withheld, then dropped after two bytes.
    gnt_auto = 1'b0; gnt_force = 1'b0;
    exp_so.push_back(8'h11); exp_so.push_back(8'h22);
    exp_done.push_back(1'b1);
    do_start(1'b0, 5'd0, 5'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("no_valid_before_gnt", {own_req, so_valid}, 2'b10);
      tick();
    end
    gnt_force = 1'b1;
    n = so_cnt + 2;
    while (so_cnt < n && done !== 1'b1) tick();
    gnt_force = 1'b0;
    check("abort_valid_drop", so_valid, 0);
    wait_done("abort");
    check("abort_err_held", err, 1);
    gnt_auto = 1'b1;

    // Asynchronous reset while a write strobe is in flight.
    si_q.push_back(8'hA1);
    do_start(1'b1, 5'd8, 5'd10);
    n = 0;
    while (rdw !== 1'b1 && n < 100) begin tick(); n++; end
    check("rdw_reached", rdw, 1);
    rst = 1'b1;
    #1;
    check("async_rst_clear", {rdw, busy, own_req, si_ready}, 0);
    si_q.delete();
    tick();
    rst = 1'b0;
    tick();
    exp_so.push_back(8'h11); exp_so.push_back(8'h22);
`ifdef MEGA_REGS_CTX_CSUM_EN
    exp_so.push_back(8'h33);
`endif
    exp_done.push_back(1'b0);
    do_start(1'b0, 5'd0, 5'd1);
    wait_done("post_rst_save");

    repeat (3) tick();
    check("exp_so_drained", exp_so.size(), 0);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
